jk_reg_bank: RTL

Parametrised successor to the single JK flip-flop: a WIDTH-bit bank of JK flip-flops sharing one clock, synchronous reset, synchronous set and clock enable. It adds three further modes: synchronous up-count (all-toggle chain), shift-left with serial in, and parallel load. The block is the general-purpose state register for the lab datapath and replaces discrete single-bit JK instances.

---
 rtl/jk_reg_bank.sv | 76 +++++++
 1 files changed

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK flip-flop bank with count, shift-left and parallel-load modes.
// Optional registered change flag enabled by defining JK_BANK_CHANGE_FLAG_EN.
module jk_reg_bank #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             S,
  input  logic             CE,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Qout,
  output logic             SO,
  output logic             TC
`ifdef JK_BANK_CHANGE_FLAG_EN
  ,
  output logic             Changed
`endif
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_COUNT = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] qout_q;
  logic [WIDTH-1:0] qout_d;

  // Next-state selection: reset, then set, then enabled mode operation, else hold.
  always_comb begin
    qout_d = qout_q;
    if (R) begin
      qout_d = {WIDTH{1'b0}};
    end else if (S) begin
      qout_d = ALL_ONES;
    end else if (CE) begin
      case (Mode)
        // Characteristic equation Q+ = J&~Q | ~K&Q, applied per bit.
        MODE_JK:    qout_d = (J & ~qout_q) | (~K & qout_q);
        MODE_COUNT: qout_d = qout_q + ONE;
        MODE_SHIFT: qout_d = {qout_q[WIDTH-2:0], SI};
        MODE_LOAD:  qout_d = D;
        default:    qout_d = qout_q;
      endcase
    end else begin
      qout_d = qout_q;
    end
  end

  // Bank state register.
  always_ff @(posedge Clk) begin
    qout_q <= qout_d;
  end

  assign Qout = qout_q;
  assign SO   = qout_q[WIDTH-1];
  assign TC   = (Mode == MODE_COUNT) && CE && (qout_q == ALL_ONES);

`ifdef JK_BANK_CHANGE_FLAG_EN
  logic changed_q;

  // Flags any edge whose next value differs from the current one, reset edges included.
  always_ff @(posedge Clk) begin
    changed_q <= (qout_d != qout_q);
  end

  assign Changed = changed_q;
`endif

endmodule
